// File: rtl/frame_pkg.sv
// Shared types and default geometry for the capture / transmit frame path.
package frame_pkg;

    localparam int FRAME_PIXELS_DEF = 76800;
    localparam int ADDR_W_DEF       = 24;

    typedef enum logic [1:0] {
        B_FREE    = 2'd0,
        B_WRITING = 2'd1,
        B_FULL    = 2'd2,
        B_READING = 2'd3
    } bank_state_t;

    typedef enum logic {
        W_IDLE    = 1'b0,
        W_CAPTURE = 1'b1
    } wr_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_BUSY = 1'b1
    } rd_state_t;

endpackage

// File: rtl/sat_counter.sv
// Event counter that holds at all ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!rstb) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/frame_bank_sched.sv
// Ping-pong bank scheduler between the pixel capture stream and the frame transmitter.
// state      | meaning
// W_IDLE     | waiting for start_frame; applies decimation and bank choice
// W_CAPTURE  | writing pixels of the current frame into wr_bank
// R_IDLE     | no bank offered; picks the oldest FULL bank
// R_BUSY     | rd_bank offered/being read until rd_done
module frame_bank_sched
    import frame_pkg::*;
#(
    parameter int FRAME_PIXELS = FRAME_PIXELS_DEF,
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int SKIP_W       = 4,
    parameter int CNT_W        = 16
) (
    input  logic              pclk,
    input  logic              rstb,
    input  logic              start_frame,
    input  logic              wr_ena,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [SKIP_W-1:0] frame_skip,
    output logic              bram_we,
    output logic [ADDR_W:0]   bram_waddr,
    output logic              capturing,
    output logic              frame_ready,
    output logic              rd_bank,
    input  logic              rd_done,
    output logic [CNT_W-1:0]  frames_dropped,
    output logic [CNT_W-1:0]  frames_aborted
);

    localparam int PIX_W = $clog2(FRAME_PIXELS + 1);
    localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(FRAME_PIXELS - 1);

    wr_state_t   wr_state, wr_state_nxt;
    rd_state_t   rd_state, rd_state_nxt;
    bank_state_t bank_st [2];
    bank_state_t bank_nxt [2];

    logic              wr_bank, wr_bank_nxt;
    logic              last_wr_bank, last_wr_bank_nxt;
    logic              first_full, first_full_nxt;
    logic              rd_bank_nxt;
    logic [SKIP_W-1:0] skip_cnt, skip_nxt;
    logic [PIX_W-1:0]  pix_cnt, pix_nxt;

    logic              accept, abort, drop, eval_start;
    logic              sel_ok, sel_bank, rd_sel_ok, rd_sel;
    logic              bram_we_nxt;
    logic [ADDR_W:0]   bram_waddr_nxt;

    always_ff @(posedge pclk) begin
        if (!rstb) begin
            wr_state     <= W_IDLE;
            rd_state     <= R_IDLE;
            bank_st[0]   <= B_FREE;
            bank_st[1]   <= B_FREE;
            wr_bank      <= 1'b0;
            last_wr_bank <= 1'b1;
            first_full   <= 1'b0;
            rd_bank      <= 1'b0;
            skip_cnt     <= '0;
            pix_cnt      <= '0;
            bram_we      <= 1'b0;
            bram_waddr   <= '0;
        end else begin
            wr_state     <= wr_state_nxt;
            rd_state     <= rd_state_nxt;
            bank_st[0]   <= bank_nxt[0];
            bank_st[1]   <= bank_nxt[1];
            wr_bank      <= wr_bank_nxt;
            last_wr_bank <= last_wr_bank_nxt;
            first_full   <= first_full_nxt;
            rd_bank      <= rd_bank_nxt;
            skip_cnt     <= skip_nxt;
            pix_cnt      <= pix_nxt;
            bram_we      <= bram_we_nxt;
            bram_waddr   <= bram_waddr_nxt;
        end
    end

    always_comb begin
        wr_state_nxt     = wr_state;
        rd_state_nxt     = rd_state;
        bank_nxt[0]      = bank_st[0];
        bank_nxt[1]      = bank_st[1];
        wr_bank_nxt      = wr_bank;
        last_wr_bank_nxt = last_wr_bank;
        first_full_nxt   = first_full;
        rd_bank_nxt      = rd_bank;
        skip_nxt         = skip_cnt;
        pix_nxt          = pix_cnt;
        accept           = 1'b0;
        abort            = 1'b0;
        drop             = 1'b0;
        eval_start       = 1'b0;
        sel_ok           = 1'b0;
        sel_bank         = 1'b0;
        rd_sel_ok        = 1'b0;
        rd_sel           = 1'b0;

        unique case (wr_state)
            W_IDLE: eval_start = start_frame;
            W_CAPTURE: begin
                if (start_frame) begin
                    abort             = 1'b1;
                    eval_start        = 1'b1;
                    bank_nxt[wr_bank] = B_FREE;
                    wr_state_nxt      = W_IDLE;
                end else if (wr_ena) begin
                    accept  = 1'b1;
                    pix_nxt = pix_cnt + PIX_W'(1);
                    if (pix_cnt == LAST_PIX) begin
                        bank_nxt[wr_bank] = B_FULL;
                        last_wr_bank_nxt  = wr_bank;
                        wr_state_nxt      = W_IDLE;
                        if (bank_st[~wr_bank] != B_FULL) begin
                            first_full_nxt = wr_bank;
                        end
                    end
                end
            end
        endcase

        // An aborted bank is already FREE in bank_nxt, so the restart may reuse it.
        if (eval_start) begin
            if (skip_cnt == '0) begin
                skip_nxt = frame_skip;
                if (bank_nxt[~last_wr_bank] == B_FREE) begin
                    sel_ok   = 1'b1;
                    sel_bank = ~last_wr_bank;
                end else if (bank_nxt[last_wr_bank] == B_FREE) begin
                    sel_ok   = 1'b1;
                    sel_bank = last_wr_bank;
                end
                if (sel_ok) begin
                    wr_state_nxt       = W_CAPTURE;
                    wr_bank_nxt        = sel_bank;
                    bank_nxt[sel_bank] = B_WRITING;
                    pix_nxt            = '0;
                end else begin
                    drop = 1'b1;
                end
            end else begin
                skip_nxt = skip_cnt - SKIP_W'(1);
            end
        end

        unique case (rd_state)
            R_IDLE: begin
                if (bank_st[0] == B_FULL && bank_st[1] == B_FULL) begin
                    rd_sel_ok = 1'b1;
                    rd_sel    = first_full;
                end else if (bank_st[0] == B_FULL) begin
                    rd_sel_ok = 1'b1;
                    rd_sel    = 1'b0;
                end else if (bank_st[1] == B_FULL) begin
                    rd_sel_ok = 1'b1;
                    rd_sel    = 1'b1;
                end
                if (rd_sel_ok) begin
                    bank_nxt[rd_sel] = B_READING;
                    rd_bank_nxt      = rd_sel;
                    rd_state_nxt     = R_BUSY;
                end
            end
            R_BUSY: begin
                if (rd_done) begin
                    bank_nxt[rd_bank] = B_FREE;
                    rd_state_nxt      = R_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        bram_we_nxt    = accept;
        bram_waddr_nxt = accept ? {wr_bank, wr_addr} : bram_waddr;
        capturing      = (wr_state == W_CAPTURE);
        frame_ready    = (rd_state == R_BUSY);
    end

    sat_counter #(.CNT_W(CNT_W)) u_drop_cnt (
        .clk   (pclk),
        .rstb  (rstb),
        .inc   (drop),
        .count (frames_dropped)
    );

    sat_counter #(.CNT_W(CNT_W)) u_abort_cnt (
        .clk   (pclk),
        .rstb  (rstb),
        .inc   (abort),
        .count (frames_aborted)
    );

endmodule

// File: tb/tb_frame_bank_sched.sv
// Directed bench for frame_bank_sched with a 16-pixel frame.
module tb_frame_bank_sched;

    localparam int FP     = 16;
    localparam int ADDR_W = 24;
    localparam int SKIP_W = 4;
    localparam int CNT_W  = 16;

    logic              pclk = 1'b0;
    logic              rstb = 1'b0;
    logic              start_frame = 1'b0;
    logic              wr_ena = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [SKIP_W-1:0] frame_skip = '0;
    logic              bram_we;
    logic [ADDR_W:0]   bram_waddr;
    logic              capturing;
    logic              frame_ready;
    logic              rd_bank;
    logic              rd_done = 1'b0;
    logic [CNT_W-1:0]  frames_dropped;
    logic [CNT_W-1:0]  frames_aborted;

    int errors = 0;
    int checks = 0;
    int we_cnt = 0;
    int we0;
    logic we_bank = 1'b0;
    logic [5:0] cap_exp;

    frame_bank_sched #(
        .FRAME_PIXELS (FP),
        .ADDR_W       (ADDR_W),
        .SKIP_W       (SKIP_W),
        .CNT_W        (CNT_W)
    ) dut (
        .pclk           (pclk),
        .rstb           (rstb),
        .start_frame    (start_frame),
        .wr_ena         (wr_ena),
        .wr_addr        (wr_addr),
        .frame_skip     (frame_skip),
        .bram_we        (bram_we),
        .bram_waddr     (bram_waddr),
        .capturing      (capturing),
        .frame_ready    (frame_ready),
        .rd_bank        (rd_bank),
        .rd_done        (rd_done),
        .frames_dropped (frames_dropped),
        .frames_aborted (frames_aborted)
    );

    always #5 pclk = ~pclk;

    task automatic step();
        @(posedge pclk);
        #1;
        if (bram_we) begin
            we_cnt++;
            we_bank = bram_waddr[ADDR_W];
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rstb = 1'b0;
        start_frame = 1'b0;
        wr_ena = 1'b0;
        rd_done = 1'b0;
        step();
        step();
        rstb = 1'b1;
        we_cnt = 0;
    endtask

    task automatic pulse_start();
        start_frame = 1'b1;
        step();
        start_frame = 1'b0;
    endtask

    task automatic pixels(input int n);
        for (int i = 0; i < n; i++) begin
            wr_ena  = 1'b1;
            wr_addr = ADDR_W'(i);
            step();
        end
        wr_ena = 1'b0;
    endtask

    task automatic read_done();
        rd_done = 1'b1;
        step();
        rd_done = 1'b0;
    endtask

    initial begin
        // Reset values
        do_reset();
        check("rst_we", bram_we, 0);
        check("rst_waddr", bram_waddr, 0);
        check("rst_capturing", capturing, 0);
        check("rst_frame_ready", frame_ready, 0);
        check("rst_rd_bank", rd_bank, 0);
        check("rst_dropped", frames_dropped, 0);
        check("rst_aborted", frames_aborted, 0);

        // Basic capture
        frame_skip = 4'd0;
        pulse_start();
        check("basic_capturing", capturing, 1);
        pixels(FP);
        check("basic_we_cnt", we_cnt, FP);
        check("basic_last_addr", bram_waddr, {1'b0, 24'd15});
        check("basic_done_idle", capturing, 0);
        check("basic_ready_early", frame_ready, 0);
        step();
        check("basic_ready", frame_ready, 1);
        check("basic_rd_bank", rd_bank, 0);
        read_done();
        check("basic_ready_clr", frame_ready, 0);

        // Ping-pong with a stalled reader
        do_reset();
        pulse_start();
        pixels(FP);
        check("pp_f1_bank", we_bank, 0);
        step();
        pulse_start();
        pixels(FP);
        check("pp_f2_bank", we_bank, 1);
        check("pp_f12_we", we_cnt, 2 * FP);
        step();
        pulse_start();
        check("pp_f3_capturing", capturing, 0);
        pixels(FP);
        check("pp_f3_we", we_cnt, 2 * FP);
        check("pp_dropped", frames_dropped, 1);
        check("pp_ready", frame_ready, 1);
        check("pp_rd_bank", rd_bank, 0);

        // Oldest-first hand-off
        read_done();
        check("ord_gap", frame_ready, 0);
        step();
        check("ord_ready2", frame_ready, 1);
        check("ord_rd_bank2", rd_bank, 1);
        read_done();
        check("ord_clr", frame_ready, 0);

        // Decimation: capture frames 1 and 4 of six
        do_reset();
        frame_skip = 4'd2;
        cap_exp = 6'b001001;
        for (int f = 0; f < 6; f++) begin
            we0 = we_cnt;
            pulse_start();
            pixels(FP);
            step();
            check($sformatf("dec_we_f%0d", f + 1), we_cnt - we0, cap_exp[f] ? FP : 0);
            check($sformatf("dec_ready_f%0d", f + 1), frame_ready, cap_exp[f]);
            if (frame_ready) read_done();
            step();
        end
        check("dec_dropped", frames_dropped, 0);

        // Abort after 10 pixels, then a full frame
        do_reset();
        frame_skip = 4'd0;
        pulse_start();
        pixels(10);
        pulse_start();
        check("abort_cnt", frames_aborted, 1);
        check("abort_capturing", capturing, 1);
        pixels(FP);
        check("abort_we", we_cnt, 10 + FP);
        check("abort_bank", we_bank, 0);
        step();
        check("abort_ready", frame_ready, 1);
        check("abort_rd_bank", rd_bank, 0);

        // Completion into bank 1 coincides with rd_done on bank 0
        pulse_start();
        for (int i = 0; i < FP; i++) begin
            wr_ena  = 1'b1;
            wr_addr = ADDR_W'(i);
            rd_done = (i == FP - 1);
            step();
        end
        wr_ena  = 1'b0;
        rd_done = 1'b0;
        check("sim_bank", we_bank, 1);
        check("sim_ready_clr", frame_ready, 0);
        check("sim_capturing", capturing, 0);
        step();
        check("sim_ready", frame_ready, 1);
        check("sim_rd_bank", rd_bank, 1);
        pulse_start();
        pixels(3);
        check("sim_freed_bank", bram_waddr[ADDR_W], 0);
        check("sim_capturing2", capturing, 1);

        // Reset mid-capture
        wr_ena = 1'b1;
        rstb = 1'b0;
        step();
        check("mrst_we", bram_we, 0);
        check("mrst_waddr", bram_waddr, 0);
        check("mrst_capturing", capturing, 0);
        check("mrst_ready", frame_ready, 0);
        check("mrst_rd_bank", rd_bank, 0);
        check("mrst_aborted", frames_aborted, 0);
        check("mrst_dropped", frames_dropped, 0);
        wr_ena = 1'b0;
        rstb = 1'b1;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/frame_bank_sched.md
Name: frame_bank_sched

Overview:
- Ping-pong frame-buffer scheduler between the HDMI capture path (rgb2bram pixel stream on pclk) and the Ethernet frame transmitter.
- Owns two BRAM banks. Decides which bank a captured frame is written into, and when a complete frame is handed to the transmitter.
- Supports frame decimation (capture 1 of N frames) and drops frames when no bank is free.

Parameters:
- FRAME_PIXELS, 76800, pixels per complete frame (320x240); capture ends after this many accepted pixels.
- ADDR_W, 24, width of the per-bank pixel address from rgb2bram.
- SKIP_W, 4, width of the frame_skip input.
- CNT_W, 16, width of the statistics counters.

Ports:
- pclk  in  1  pixel clock; the only clock.
- rstb  in  1  reset; synchronous, active-low.
- start_frame  in  1  one-cycle pulse at the first pixel of each incoming frame.
- wr_ena  in  1  pixel-valid strobe from rgb2bram.
- wr_addr  in  ADDR_W  pixel address within a frame.
- frame_skip  in  SKIP_W  capture one frame, then skip frame_skip frames.
- bram_we  out  1  BRAM write enable.
- bram_waddr  out  ADDR_W+1  {bank, wr_addr}.
- capturing  out  1  high while a capture is in progress.
- frame_ready  out  1  a full bank is offered to the transmitter.
- rd_bank  out  1  bank being offered or read.
- rd_done  in  1  pulse: transmitter has finished reading rd_bank.
- frames_dropped  out  CNT_W  frames lost because no bank was free.
- frames_aborted  out  CNT_W  captures cut short by an early start_frame.

Behaviour:
- Reset (rstb=0 at a pclk edge) produces:
  - both banks FREE; writer W_IDLE; reader R_IDLE; skip_cnt=0; last_wr_bank=1;
  - all outputs 0, counters 0.
- Per-bank state: FREE, WRITING, FULL, READING.
- Writer FSM, W_IDLE:
  - On start_frame with skip_cnt==0: load skip_cnt <= frame_skip.
    - If a FREE bank exists, go to W_CAPTURE and set wr_bank. Prefer bank != last_wr_bank; otherwise take the only FREE bank. Mark that bank WRITING and clear pix_cnt.
    - If no bank is FREE, increment frames_dropped (saturating) and stay in W_IDLE.
  - On start_frame with skip_cnt!=0: skip_cnt <= skip_cnt-1 and stay in W_IDLE.
- Writer FSM, W_CAPTURE:
  - Pixel acceptance: bram_we=wr_ena and bram_waddr={wr_bank, wr_addr}, both registered, 1-cycle latency. pix_cnt increments on each wr_ena.
  - Completion: wr_ena with pix_cnt==FRAME_PIXELS-1 accepts the last pixel, then:
    - bank becomes FULL; last_wr_bank <= wr_bank;
    - record the completion order so the reader takes the older full bank first;
    - return to W_IDLE.
  - Early start_frame (before completion):
    - the bank returns to FREE and frames_aborted increments (saturating);
    - the same start_frame is then evaluated as in W_IDLE in that cycle, including the skip and bank choice.
  - wr_ena in W_IDLE never asserts bram_we.
- capturing = (writer state == W_CAPTURE), registered.
- Reader FSM:
  - R_IDLE: if any bank is FULL, select the oldest, drive rd_bank, set that bank READING and frame_ready=1, then go to R_BUSY.
  - R_BUSY: frame_ready stays 1 until rd_done.
    - On rd_done: the bank becomes FREE, frame_ready=0, return to R_IDLE.
    - A FULL bank can be offered again no earlier than the next cycle.
  - rd_done in R_IDLE is ignored.
- Simultaneous events:
  - Capture completion and rd_done in the same cycle both take effect. The freed bank is eligible at the next start_frame.
  - start_frame and rd_done in the same cycle: bank selection sees the bank as still READING. No combinational bypass.
  - Capture completing while the reader is idle: frame_ready rises 2 cycles after the last accepted pixel (1 cycle to FULL, 1 cycle reader).
- Counters saturate at all ones.
- Reset asserted mid-capture or mid-read discards everything, with no partial-frame handoff.

Decomposition:
- Shared package frame_pkg:
  - bank state enum (FREE/WRITING/FULL/READING);
  - writer enum (W_IDLE/W_CAPTURE) and reader enum (R_IDLE/R_BUSY);
  - default FRAME_PIXELS and ADDR_W constants, shared with rgb2bram and the Ethernet reader.
- One natural sub-module: sat_counter (CNT_W, increment enable, saturate), instantiated twice for the statistics counters.
- The FSMs stay in frame_bank_sched.

Test Plan:
- Basic capture, frame_skip=0:
  - Stimulus: reset; start_frame, then 76800 wr_ena pulses (use FRAME_PIXELS=16 in a fast run); reader idle.
  - Required: bram_waddr[ADDR_W]=0, bram_we count=16, frame_ready=1 with rd_bank=0 two cycles after the last pixel.
  - Then rd_done: frame_ready=0.
- Ping-pong and backpressure:
  - Stimulus: reader never asserts rd_done; three frames of 16 pixels.
  - Required: frames 1 and 2 go to banks 0 and 1; frame 3 is not written (no bram_we); frames_dropped=1.
- Oldest-first order:
  - Stimulus: bank0 and bank1 both FULL, reader busy on neither.
  - Required: first offer rd_bank=0; after rd_done, rd_bank=1 offered one cycle later.
- Decimation:
  - Stimulus: frame_skip=2; six frames, each fully read out.
  - Required: only frames 1 and 4 captured; frames_dropped=0.
- Abort:
  - Stimulus: start_frame after 10 of 16 pixels.
  - Required: frames_aborted=1; the aborted bank becomes FREE; the new frame is captured into the preferred bank and completes normally.
- Simultaneous and reset:
  - Stimulus: capture completion in the same cycle as rd_done of the other bank.
  - Required: both banks update as specified.
  - Stimulus: rstb=0 mid-capture.
  - Required: the next cycle shows all outputs and counters at 0.
